memory1_arbiter: RTL

Two-requester round-robin controller in front of a single-port `memory1` instance (`ce`-gated, read-before-write on every access). Every enabled memory cycle also writes, so the block turns a plain read into a two-cycle destructive read plus restore, while a write takes one memory cycle. Requesters see a simple req/ack handshake and never drive the memory directly.

---
 rtl/memory1_arbiter_if.sv | 16 +
 rtl/memory1_arbiter.sv | 107 ++++++++++
 2 files changed

// File: rtl/memory1_arbiter_if.sv
// Requester-side req/ack handshake for one port of memory1_arbiter.
// The requester drives req/we/addr/wdata; the arbiter answers with ack/rvalid.
interface memory1_arbiter_if #(
   parameter int AWIDTH = 8,
   parameter int DWIDTH = 32
);
   logic              req;
   logic              we;
   logic [AWIDTH-1:0] addr;
   logic [DWIDTH-1:0] wdata;
   logic              ack;
   logic              rvalid;

   modport master (output req, we, addr, wdata, input ack, rvalid);
   modport slave  (input req, we, addr, wdata, output ack, rvalid);
endinterface

// File: rtl/memory1_arbiter.sv
// Two-requester round-robin front end for a single-port, read-before-write memory1.
// Reads are destructive (the memory writes zeros) and are followed by a restore cycle.
module memory1_arbiter #(
   parameter int AWIDTH = 8,
   parameter int DWIDTH = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   memory1_arbiter_if.slave  rq0,
   memory1_arbiter_if.slave  rq1,
   output logic [DWIDTH-1:0] rdata,
   output logic              mem_ce,
   output logic [AWIDTH-1:0] mem_addr,
   output logic [DWIDTH-1:0] mem_wdata,
   input  logic [DWIDTH-1:0] mem_rdata
);

   typedef enum logic [2:0] {IDLE, WR, RD, RESTORE, ACK} state_t;

   state_t            state_q, state_d;
   logic              gnt_q, gnt_d;
   logic              last_gnt_q, last_gnt_d;
   logic              we_q, we_d;
   logic [AWIDTH-1:0] addr_q, addr_d;
   logic [DWIDTH-1:0] wdata_q, wdata_d;
   logic [DWIDTH-1:0] rdata_q, rdata_d;
   logic              any_req;
   logic              win;
   logic              win_we;

   // On a tie the requester that did not win last time is served.
   assign any_req = rq0.req | rq1.req;
   assign win     = (rq0.req & rq1.req) ? ~last_gnt_q : rq1.req;
   assign win_we  = win ? rq1.we : rq0.we;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         gnt_q      <= 1'b0;
         last_gnt_q <= 1'b1;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         last_gnt_q <= last_gnt_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      last_gnt_d = last_gnt_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      unique case (state_q)
         IDLE: begin
            if (any_req) begin
               gnt_d      = win;
               last_gnt_d = win;
               we_d       = win_we;
               addr_d     = win ? rq1.addr  : rq0.addr;
               wdata_d    = win ? rq1.wdata : rq0.wdata;
               state_d    = win_we ? WR : RD;
            end
         end
         WR:      state_d = ACK;
         RD:      state_d = RESTORE;
         RESTORE: begin
            state_d = ACK;
            rdata_d = mem_rdata;
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // RESTORE writes back the word the RD cycle just returned, so the data path
   // from mem_rdata is combinational. Gating ce with rst_n leaves a location
   // zeroed if reset lands in RESTORE instead of writing it back.
   always_comb begin
      mem_wdata = wdata_q;
      case (state_q)
         RD:      mem_wdata = '0;
         RESTORE: mem_wdata = mem_rdata;
         default: mem_wdata = wdata_q;
      endcase
   end

   assign mem_ce    = rst_n & ((state_q == WR) | (state_q == RD) | (state_q == RESTORE));
   assign mem_addr  = addr_q;
   assign rdata     = rdata_q;

   assign rq0.ack    = (state_q == ACK) & ~gnt_q;
   assign rq1.ack    = (state_q == ACK) &  gnt_q;
   assign rq0.rvalid = rq0.ack & ~we_q;
   assign rq1.rvalid = rq1.ack & ~we_q;

endmodule
